// File: rtl/video_timing_pkg.sv
// Shared VGA timing constants and per-axis timing description for the video timing generator.
package video_timing_pkg;

  // Default VGA 640x480@60 horizontal terms, in pixels
  localparam int unsigned VGA_H_ACTIVE      = 640;
  localparam int unsigned VGA_H_FRONT_PORCH = 16;
  localparam int unsigned VGA_H_SYNC        = 96;
  localparam int unsigned VGA_H_BACK_PORCH  = 48;

  // Default VGA 640x480@60 vertical terms, in lines
  localparam int unsigned VGA_V_ACTIVE      = 480;
  localparam int unsigned VGA_V_FRONT_PORCH = 10;
  localparam int unsigned VGA_V_SYNC        = 2;
  localparam int unsigned VGA_V_BACK_PORCH  = 33;

  // One axis of the raster: active span, blanking split and sync level
  typedef struct packed {
    int unsigned active;
    int unsigned front_porch;
    int unsigned sync;
    int unsigned back_porch;
    logic        polarity;
  } axis_timing_t;

  localparam axis_timing_t VGA_H_TIMING = '{
    active:      VGA_H_ACTIVE,
    front_porch: VGA_H_FRONT_PORCH,
    sync:        VGA_H_SYNC,
    back_porch:  VGA_H_BACK_PORCH,
    polarity:    1'b0
  };

  localparam axis_timing_t VGA_V_TIMING = '{
    active:      VGA_V_ACTIVE,
    front_porch: VGA_V_FRONT_PORCH,
    sync:        VGA_V_SYNC,
    back_porch:  VGA_V_BACK_PORCH,
    polarity:    1'b0
  };

  // Full period of one axis
  function automatic int unsigned axis_total(axis_timing_t t);
    return t.active + t.front_porch + t.sync + t.back_porch;
  endfunction

  // Bit width able to hold 0..n-1, never below one bit
  function automatic int unsigned width_of(int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/video_timing_generator_axis.sv
// One raster axis: wrapping position counter with active and sync window decode.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter axis_timing_t TIMING = VGA_H_TIMING,
  localparam int unsigned TOTAL  = axis_total(TIMING),
  localparam int unsigned CW     = width_of(TOTAL)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          adv_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_c_o,
  output logic          active_c_o,
  output logic          sync_c_o
);

  localparam int unsigned SYNC_FIRST = TIMING.active + TIMING.front_porch;
  localparam int unsigned SYNC_LAST  = SYNC_FIRST + TIMING.sync - 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Wrap only fires on an advance from the last position of the period
  assign wrap_c_o = adv_i && (count_q == CW'(TOTAL - 1));

  // Next position: hold, step, or return to zero at end of period
  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = wrap_c_o ? '0 : count_q + 1'b1;
    end
  end

  // Position register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Inclusive-bound compares keep every constant inside CW bits
  assign active_c_o = (count_q <= CW'(TIMING.active - 1));
  assign sync_c_o   = (count_q >= CW'(SYNC_FIRST)) && (count_q <= CW'(SYNC_LAST));
  assign count_o    = count_q;

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing for the falling-sand VGA path: syncs, active window, coordinates,
// linear frame-buffer address, line/frame strobes and a vblank-aligned swap handshake.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_COLUMNS         = VGA_H_ACTIVE,
  parameter int unsigned FRONT_PORCH_HORIZONTAL = VGA_H_FRONT_PORCH,
  parameter int unsigned SYNC_HORIZONTAL        = VGA_H_SYNC,
  parameter int unsigned BACK_PORCH_HORIZONTAL  = VGA_H_BACK_PORCH,
  parameter int unsigned ACTIVE_ROWS            = VGA_V_ACTIVE,
  parameter int unsigned FRONT_PORCH_VERTICAL   = VGA_V_FRONT_PORCH,
  parameter int unsigned SYNC_VERTICAL          = VGA_V_SYNC,
  parameter int unsigned BACK_PORCH_VERTICAL    = VGA_V_BACK_PORCH,
  parameter logic        HSYNC_POLARITY         = 1'b0,
  parameter logic        VSYNC_POLARITY         = 1'b0,
  parameter int unsigned PIXEL_DIV              = 1,
  localparam int unsigned XW = width_of(ACTIVE_COLUMNS),
  localparam int unsigned YW = width_of(ACTIVE_ROWS),
  localparam int unsigned AW = width_of(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic          swap_req_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_en_o,
  output logic          vblank_o,
  output logic          pix_tick_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          swap_ack_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [AW-1:0] pixel_o
);

  localparam axis_timing_t H_TIMING = '{
    active:      ACTIVE_COLUMNS,
    front_porch: FRONT_PORCH_HORIZONTAL,
    sync:        SYNC_HORIZONTAL,
    back_porch:  BACK_PORCH_HORIZONTAL,
    polarity:    HSYNC_POLARITY
  };

  localparam axis_timing_t V_TIMING = '{
    active:      ACTIVE_ROWS,
    front_porch: FRONT_PORCH_VERTICAL,
    sync:        SYNC_VERTICAL,
    back_porch:  BACK_PORCH_VERTICAL,
    polarity:    VSYNC_POLARITY
  };

  localparam int unsigned TOTAL_COLUMNS = axis_total(H_TIMING);
  localparam int unsigned TOTAL_ROWS    = axis_total(V_TIMING);
  localparam int unsigned HW            = width_of(TOTAL_COLUMNS);
  localparam int unsigned VW            = width_of(TOTAL_ROWS);
  localparam int unsigned DW            = width_of(PIXEL_DIV);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          tick_c;
  logic          first_c;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          h_active_c;
  logic          v_active_c;
  logic          h_sync_c;
  logic          v_sync_c;
  logic          active_c;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  logic          hsync_q,       hsync_d;
  logic          vsync_q,       vsync_d;
  logic          video_en_q,    video_en_d;
  logic          vblank_q,      vblank_d;
  logic          pix_tick_q,    pix_tick_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          swap_ack_q,    swap_ack_d;
  logic [XW-1:0] x_q,           x_d;
  logic [YW-1:0] y_q,           y_d;
  logic [AW-1:0] pixel_q,       pixel_d;

  // A pixel advances on the last divider phase; div_q == 0 marks the first clk of a position
  assign tick_c  = enable_i && (div_q == DW'(PIXEL_DIV - 1));
  assign first_c = (div_q == '0);

  // Pixel-clock divider, frozen while disabled
  always_comb begin
    div_d = div_q;
    if (enable_i) begin
      div_d = tick_c ? '0 : div_q + 1'b1;
    end
  end

  timing_axis_counter #(
    .TIMING (H_TIMING)
  ) u_h_axis (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .adv_i      (tick_c),
    .count_o    (h_count),
    .wrap_c_o   (h_wrap_c),
    .active_c_o (h_active_c),
    .sync_c_o   (h_sync_c)
  );

  // Rows step only when a line wraps, so vsync can only change at a line start
  timing_axis_counter #(
    .TIMING (V_TIMING)
  ) u_v_axis (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .adv_i      (h_wrap_c),
    .count_o    (v_count),
    .wrap_c_o   (v_wrap_c),
    .active_c_o (v_active_c),
    .sync_c_o   (v_sync_c)
  );

  assign active_c = h_active_c && v_active_c;

  // Linear address of the current position: steps past each active pixel, holds in blanking,
  // and returns to zero as the raster wraps back to (0,0)
  always_comb begin
    addr_d = addr_q;
    if (tick_c) begin
      if (h_wrap_c && v_wrap_c) begin
        addr_d = '0;
      end else if (active_c) begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Output decode of the current counters; strobes only on the first clk of a position
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_en_d    = video_en_q;
    vblank_d      = vblank_q;
    x_d           = x_q;
    y_d           = y_q;
    pixel_d       = pixel_q;
    pix_tick_d    = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    swap_ack_d    = 1'b0;
    if (enable_i) begin
      hsync_d       = h_sync_c ? HSYNC_POLARITY : ~HSYNC_POLARITY;
      vsync_d       = v_sync_c ? VSYNC_POLARITY : ~VSYNC_POLARITY;
      video_en_d    = active_c;
      vblank_d      = !v_active_c;
      x_d           = active_c ? h_count[XW-1:0] : '0;
      y_d           = active_c ? v_count[YW-1:0] : '0;
      pixel_d       = active_c ? addr_q : '0;
      pix_tick_d    = tick_c;
      line_start_d  = first_c && (h_count == '0);
      frame_start_d = first_c && (h_count == '0) && (v_count == '0);
      swap_ack_d    = swap_req_i && first_c && (h_count == '0)
                      && (v_count == VW'(ACTIVE_ROWS));
    end
  end

  // Divider, address and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q         <= '0;
      addr_q        <= '0;
      hsync_q       <= ~HSYNC_POLARITY;
      vsync_q       <= ~VSYNC_POLARITY;
      video_en_q    <= 1'b0;
      vblank_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_q       <= '0;
    end else begin
      div_q         <= div_d;
      addr_q        <= addr_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_en_q    <= video_en_d;
      vblank_q      <= vblank_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pixel_q       <= pixel_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_en_o    = video_en_q;
  assign vblank_o      = vblank_q;
  assign pix_tick_o    = pix_tick_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign swap_ack_o    = swap_ack_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign pixel_o       = pixel_q;

endmodule
